// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Core-wide constants shared by the front end.
//   XLEN        : architectural register / PC / instruction width
//   FETCH_WIDTH : instructions fetched per cycle
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_WIDTH = 2;

endpackage : core_pkg

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// Program counter register and next-PC selection for the two-wide fetch stage.
// Priority: redirect > stall > fetch_en (advance by one pair) > hold.
//
// Ports
//   clk          in   core clock
//   reset        in   asynchronous active-low reset
//   fetch_en     in   permits the PC to advance
//   stall        in   decode back-pressure; PC holds
//   redirect_en  in   load redirect_pc
//   redirect_pc  in   redirect target (word aligned)
//   pc           out  current fetch PC
// -----------------------------------------------------------------------------
module fetch_pc_gen
  import core_pkg::*;
#(
  parameter int              PC_W     = XLEN,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc
);

  // One pair of 4-byte words per fetch.
  localparam logic [PC_W-1:0] PAIR_STEP = PC_W'(4'd8);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;

  // Next-PC selection in priority order; the sum wraps modulo 2^PC_W.
  always_comb begin
    w_pc_next = r_pc;
    if (redirect_en) begin
      w_pc_next = redirect_pc;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (fetch_en) begin
      w_pc_next = r_pc + PAIR_STEP;
    end else begin
      w_pc_next = r_pc;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc = r_pc;

endmodule : fetch_pc_gen

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
// Two-wide in-order instruction fetch stage. Issues PC and PC+4 to a dual-port
// synchronous instruction memory (1-cycle read latency) and presents the
// returned pair, with PCs and valid bits, to decode. Supports a global stall
// and a back-end redirect that squashes the in-flight request.
//
// Ports
//   clk            in   core clock, rising edge
//   reset          in   asynchronous active-low reset
//   fetch_en       in   permits new fetch requests
//   stall          in   decode cannot accept; hold PC and presented outputs
//   redirect_en    in   one-cycle pulse: load redirect_pc, squash in-flight
//   redirect_pc    in   redirect target (word aligned)
//   if_valid       out  per-slot valid (both slots always equal)
//   if_pc          out  per-slot PC (slot i = request PC + 4*i)
//   if_instr       out  per-slot instruction (straight from memory data)
//   imem_addr0     out  port 0 byte address (= PC)
//   imem_addr1     out  port 1 byte address (= PC + 4)
//   imem_ren       out  read enable for both ports
//   imem_rdata0/1  in   data for the previous cycle's addr0/addr1
// -----------------------------------------------------------------------------
module fetch
  import core_pkg::*;
#(
  parameter int                 FETCH_W  = FETCH_WIDTH,
  parameter int                 PC_W     = XLEN,
  parameter int                 INSTR_W  = XLEN,
  parameter logic [PC_W-1:0]    RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               stall,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [FETCH_W-1:0] if_valid,
  output logic [PC_W-1:0]    if_pc    [FETCH_W-1:0],
  output logic [INSTR_W-1:0] if_instr [FETCH_W-1:0],
  output logic [PC_W-1:0]    imem_addr0,
  output logic [PC_W-1:0]    imem_addr1,
  output logic               imem_ren,
  input  logic [INSTR_W-1:0] imem_rdata0,
  input  logic [INSTR_W-1:0] imem_rdata1
);

  localparam logic [PC_W-1:0] WORD_STEP = PC_W'(3'd4);

  logic [PC_W-1:0] w_pc;
  logic [PC_W-1:0] r_req_pc;
  logic            r_req_valid;

  fetch_pc_gen #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .pc          (w_pc)
  );

  // Both ports address consecutive words of the current PC.
  assign imem_addr0 = w_pc;
  assign imem_addr1 = w_pc + WORD_STEP;

  // The memory only updates its data when ren is high, so keeping ren low
  // during stall/redirect/reset is what holds the presented instructions.
  assign imem_ren = reset & fetch_en & ~stall & ~redirect_en;

  // Outstanding-request tracking: redirect squashes, stall holds, fetch issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_pc    <= RESET_PC;
      r_req_valid <= 1'b0;
    end else if (redirect_en) begin
      r_req_pc    <= r_req_pc;
      r_req_valid <= 1'b0;
    end else if (stall) begin
      r_req_pc    <= r_req_pc;
      r_req_valid <= r_req_valid;
    end else if (fetch_en) begin
      r_req_pc    <= w_pc;
      r_req_valid <= 1'b1;
    end else begin
      r_req_pc    <= r_req_pc;
      r_req_valid <= 1'b0;
    end
  end

  // Slot valids and PCs derive from the single outstanding request.
  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      if_valid[i] = r_req_valid;
      if_pc[i]    = r_req_pc + PC_W'(32'(i) << 2);
    end
  end

  assign if_instr[0] = imem_rdata0;
  assign if_instr[1] = imem_rdata1;

endmodule : fetch

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch
// Directed bench for the two-wide fetch stage with a dual-port synchronous
// instruction memory model (word k = 0x11111111*(k+1) for k=0..5, NOP else).
// -----------------------------------------------------------------------------
module tb_fetch;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [1:0]  if_valid;
  logic [31:0] if_pc    [1:0];
  logic [31:0] if_instr [1:0];
  logic [31:0] imem_addr0;
  logic [31:0] imem_addr1;
  logic        imem_ren;
  logic [31:0] imem_rdata0;
  logic [31:0] imem_rdata1;

  int checks;
  int failures;

  fetch dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .imem_addr0  (imem_addr0),
    .imem_addr1  (imem_addr1),
    .imem_ren    (imem_ren),
    .imem_rdata0 (imem_rdata0),
    .imem_rdata1 (imem_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] k;
    k = addr >> 2;
    if (k <= 32'd5) return 32'h11111111 * (k + 32'd1);
    else            return 32'h00000013;
  endfunction

  // Synchronous dual-port memory, updates only on read enable.
  always @(posedge clk) begin
    if (imem_ren) begin
      imem_rdata0 <= mem_word(imem_addr0);
      imem_rdata1 <= mem_word(imem_addr1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [98:0] obs;
    fetch_en = 1'b1;
    #12;
    obs = {if_valid, if_pc[0], if_pc[1], imem_addr0, imem_ren};
    checks++;
    if (obs !== {2'b00, 32'h0, 32'h4, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", obs, {2'b00, 32'h0, 32'h4, 32'h0, 1'b0});
    end
  endtask

  task automatic test_sequential();
    logic [129:0] obs;
    logic [129:0] exp_v [3];
    exp_v[0] = {2'b11, 32'h0,  32'h4,  32'h11111111, 32'h22222222};
    exp_v[1] = {2'b11, 32'h8,  32'hC,  32'h33333333, 32'h44444444};
    exp_v[2] = {2'b11, 32'h10, 32'h14, 32'h55555555, 32'h66666666};
    reset = 1'b1;
    #1;
    checks++;
    if (imem_ren !== 1'b1) begin
      failures++;
      $display("FAIL seq_ren_after_release: got %b expected 1", imem_ren);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]};
      checks++;
      if (obs !== exp_v[i]) begin
        failures++;
        $display("FAIL seq_pair%0d: got %h expected %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [129:0] obs;
    stall = 1'b1;
    #1;
    checks++;
    if (imem_ren !== 1'b0) begin
      failures++;
      $display("FAIL stall_ren: got %b expected 0", imem_ren);
    end
    tick();
    obs = {if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]};
    checks++;
    if (obs !== {2'b11, 32'h10, 32'h14, 32'h55555555, 32'h66666666}) begin
      failures++;
      $display("FAIL stall_hold: got %h expected %h", obs,
               {2'b11, 32'h10, 32'h14, 32'h55555555, 32'h66666666});
    end
    stall = 1'b0;
    #1;
    checks++;
    if ({imem_ren, imem_addr0, imem_addr1} !== {1'b1, 32'h18, 32'h1C}) begin
      failures++;
      $display("FAIL stall_resume_addr: got %h expected %h",
               {imem_ren, imem_addr0, imem_addr1}, {1'b1, 32'h18, 32'h1C});
    end
    tick();
    obs = {if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]};
    checks++;
    if (obs !== {2'b11, 32'h18, 32'h1C, 32'h13, 32'h13}) begin
      failures++;
      $display("FAIL stall_next_pair: got %h expected %h", obs,
               {2'b11, 32'h18, 32'h1C, 32'h13, 32'h13});
    end
  endtask

  task automatic test_redirect(input logic with_stall);
    logic [129:0] obs;
    redirect_en = 1'b1;
    redirect_pc = 32'h8;
    stall       = with_stall;
    #1;
    checks++;
    if (imem_ren !== 1'b0) begin
      failures++;
      $display("FAIL redirect_ren(stall=%0b): got %b expected 0", with_stall, imem_ren);
    end
    tick();
    redirect_en = 1'b0;
    stall       = 1'b0;
    #1;
    checks++;
    if ({if_valid, imem_addr0, imem_ren} !== {2'b00, 32'h8, 1'b1}) begin
      failures++;
      $display("FAIL redirect_bubble(stall=%0b): got %h expected %h", with_stall,
               {if_valid, imem_addr0, imem_ren}, {2'b00, 32'h8, 1'b1});
    end
    tick();
    obs = {if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]};
    checks++;
    if (obs !== {2'b11, 32'h8, 32'hC, 32'h33333333, 32'h44444444}) begin
      failures++;
      $display("FAIL redirect_target(stall=%0b): got %h expected %h", with_stall, obs,
               {2'b11, 32'h8, 32'hC, 32'h33333333, 32'h44444444});
    end
  endtask

  task automatic test_fetch_disable();
    logic [129:0] obs;
    fetch_en = 1'b0;
    #1;
    checks++;
    if (imem_ren !== 1'b0) begin
      failures++;
      $display("FAIL disable_ren: got %b expected 0", imem_ren);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({if_valid, imem_addr0} !== {2'b00, 32'h10}) begin
        failures++;
        $display("FAIL disable_idle%0d: got %h expected %h", i,
                 {if_valid, imem_addr0}, {2'b00, 32'h10});
      end
    end
    fetch_en = 1'b1;
    tick();
    obs = {if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]};
    checks++;
    if (obs !== {2'b11, 32'h10, 32'h14, 32'h55555555, 32'h66666666}) begin
      failures++;
      $display("FAIL disable_resume: got %h expected %h", obs,
               {2'b11, 32'h10, 32'h14, 32'h55555555, 32'h66666666});
    end
  endtask

  task automatic test_async_reset();
    logic [129:0] obs;
    #2;
    reset = 1'b0;
    #1;
    obs = {2'b00, if_valid, if_pc[0], if_pc[1], imem_addr0, imem_ren, 29'd0};
    checks++;
    if ({if_valid, if_pc[0], if_pc[1], imem_addr0, imem_ren} !==
        {2'b00, 32'h0, 32'h4, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_immediate: got %h expected %h",
               {if_valid, if_pc[0], if_pc[1], imem_addr0, imem_ren},
               {2'b00, 32'h0, 32'h4, 32'h0, 1'b0});
    end
    tick();
    reset = 1'b1;
    tick();
    obs = {if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]};
    checks++;
    if (obs !== {2'b11, 32'h0, 32'h4, 32'h11111111, 32'h22222222}) begin
      failures++;
      $display("FAIL async_reset_restart: got %h expected %h", obs,
               {2'b11, 32'h0, 32'h4, 32'h11111111, 32'h22222222});
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    fetch_en    = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_fetch_disable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch

// File: doc/fetch.md
# fetch

Two-wide in-order instruction fetch stage at the front of the superscalar core. Holds the program counter, issues two sequential word addresses per cycle to a dual-port synchronous instruction memory (1-cycle read latency), and presents the returned instruction pair with their PCs and valid bits to decode. Supports a global stall and a branch/exception redirect from the back end.

## Interface
- FETCH_W, default core_pkg::FETCH_WIDTH (2): slots per cycle; only 2 is supported, matching the two memory ports.
- PC_W, default core_pkg::XLEN (32): PC width.
- INSTR_W, default core_pkg::XLEN (32): instruction width.
- RESET_PC, default 0: PC loaded on reset.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits new fetch requests.
- stall  in  1  decode cannot accept; hold the PC and the presented outputs.
- redirect_en  in  1  one-cycle pulse; load redirect_pc and squash in-flight fetch.
- redirect_pc  in  PC_W  redirect target; word-aligned.
- if_valid  out  FETCH_W  per-slot valid.
- if_pc  out  [FETCH_W] x PC_W  slot PCs, unpacked array indexed [FETCH_W-1:0].
- if_instr  out  [FETCH_W] x INSTR_W  slot instructions, unpacked array.
- imem_addr0  out  PC_W  byte address, port 0 (= PC).
- imem_addr1  out  PC_W  byte address, port 1 (= PC+4).
- imem_ren  out  1  read enable for both ports.
- imem_rdata0  in  INSTR_W  data for the previous cycle's addr0.
- imem_rdata1  in  INSTR_W  data for the previous cycle's addr1.

## Operation
- State: pc, req_pc_q (PC of the outstanding/presented request), req_valid_q.
- imem_addr0 = pc; imem_addr1 = pc + 4, wrapping modulo 2^PC_W; both combinational from pc.
- imem_ren = fetch_en & ~stall & ~redirect_en.
- Per edge, in priority order:
  - redirect_en: pc <= redirect_pc; req_valid_q <= 0. Redirect overrides stall and fetch_en.
  - stall: pc, req_pc_q and req_valid_q hold.
  - fetch_en: req_pc_q <= pc; req_valid_q <= 1; pc <= pc + 8.
  - otherwise: pc holds; req_valid_q <= 0.
- Outputs: if_valid[i] = req_valid_q; if_pc[i] = req_pc_q + 4*i; if_instr[0] = imem_rdata0; if_instr[1] = imem_rdata1.
- Memory contract: the memory updates rdata only when imem_ren is high. Because ren is low during stall, the presented instructions stay stable.
- No alignment restriction beyond word alignment. Both slots are always valid together; there is no partial-pair fetch and no branch prediction.
- Reset: pc = RESET_PC, req_pc_q = RESET_PC, req_valid_q = 0. Hence if_valid = 0, if_pc = {RESET_PC+4, RESET_PC}, imem_ren = 0 while reset is asserted.

## Timing
- Fetch latency 1 cycle: a request issued at PC p in cycle n is presented in cycle n+1 as p / p+4 with valid = 11.
- Throughput: one pair per cycle when unstalled (PC advances by 8).
- Stall asserted in cycle n: the edge ending cycle n holds all state, and outputs in cycle n+1 equal those in cycle n. The first new pair appears one cycle after stall drops.
- Redirect in cycle n: cycle n+1 has valid = 00 and pc = redirect_pc issuing. Cycle n+2 presents redirect_pc / redirect_pc+4.
- fetch_en deasserted: valid drops the following cycle and pc holds.
- Reset mid-operation clears valid immediately (asynchronous); fetch resumes from RESET_PC.

## Structure
- core_pkg supplies XLEN = 32 and FETCH_WIDTH = 2; this block adds no types.
- Single flat module. An optional sub-module, fetch_pc_gen (pc register plus next-PC mux), is a natural split.

## Test plan
- Memory is loaded with word k = 0x11111111·(k+1) for k = 0..5, and NOP 0x00000013 elsewhere.
- Reset release with fetch_en = 1: first valid cycle shows PC 0x0/0x4 with 0x11111111/0x22222222; the next cycle shows 0x8/0xC with 0x33333333/0x44444444; then 0x10/0x14 with 0x55555555/0x66666666.
- Stall for one cycle mid-stream: the output pair and PC are repeated exactly for one extra cycle, imem_ren = 0 that cycle, and there is no skipped pair.
- redirect_pc = 0x08 pulse: the next cycle shows if_valid = 00 and imem_addr0 = 0x08; the cycle after shows 0x08/0x0C with 0x33333333/0x44444444.
- Redirect and stall asserted together: redirect wins and the same sequence as the previous scenario follows.
- fetch_en = 0 for two cycles: valid = 00 from the next cycle and pc frozen; resumes with the next sequential pair.
- Asynchronous reset asserted between edges: if_valid drops at once; after release, fetch restarts at 0x0.
